// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests under a credit limit,
// buffers returned words with their PC for decode, squashes wrong-path words on redirect.
// Optional build macro FETCH_STATS_EN adds redirect_count and squash_count outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_reset_branch,
  input  logic [31:0] reset_address,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [31:0] squash_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t         state;
  state_t         state_next;
  logic [31:0]    pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop;
  logic [CW-1:0]  fifo_count;
  logic [PW-1:0]  fifo_rd;
  logic [PW-1:0]  fifo_wr;
  logic [PW-1:0]  pcq_rd;
  logic [PW-1:0]  pcq_wr;

  logic [31:0]    fifo_data [FIFO_DEPTH];
  logic [31:0]    fifo_pc   [FIFO_DEPTH];
  logic [31:0]    pcq       [FIFO_DEPTH];

  logic [CW:0]    credit_used;
  logic           rsp;
  logic           accept;
  logic           drop_rsp;
  logic           push;
  logic           pop;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^reset_address[1:0];

  // Responses with nothing outstanding belong to requests issued before a reset; ignore them.
  assign rsp         = imem_rsp_valid && (outstanding != '0);
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

  assign imem_req_valid = (state == RUN) && !pc_reset_branch &&
                          (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign drop_rsp = rsp && (pc_reset_branch || (drop != '0));
  assign push     = rsp && !drop_rsp;
  assign pop      = instr_valid && instr_ready && !pc_reset_branch;

  assign instr_valid = (fifo_count != '0);
  assign instr_data  = instr_valid ? fifo_data[fifo_rd] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[fifo_rd]   : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else if (pc_reset_branch) begin
      // Every request still in flight is wrong-path, including any already marked for dropping.
      pc          <= {reset_address[31:2], 2'b00};
      outstanding <= outstanding - CW'(rsp);
      drop        <= outstanding - CW'(rsp);
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      if (accept) begin
        pc     <= pc + 32'd4;
        pcq_wr <= pcq_wr + PW'(1);
      end
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (drop_rsp) begin
        drop <= drop - CW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) begin
        fifo_wr <= fifo_wr + PW'(1);
        pcq_rd  <= pcq_rd + PW'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pcq[pcq_wr] <= pc;
    end
    if (push) begin
      fifo_data[fifo_wr] <= imem_rsp_data;
      fifo_pc[fifo_wr]   <= pcq[pcq_rd];
    end
  end

`ifdef FETCH_STATS_EN
  logic [CW:0] squash_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  assign squash_inc = (pc_reset_branch ? {1'b0, fifo_count} : '0) + (CW + 1)'(drop_rsp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= 32'h0;
      squash_count   <= 32'h0;
    end else begin
      redirect_count <= sat_add(redirect_count, 32'(pc_reset_branch));
      squash_count   <= sat_add(squash_count, 32'(squash_inc));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every cycle,
// an in-order imem responder with adjustable latency, and literal expectations per scenario.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_reset_branch;
  logic [31:0] reset_address;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] redirect_count;
  logic [31:0] squash_count;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_reset_branch (pc_reset_branch),
    .reset_address   (reset_address),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc)
`ifdef FETCH_STATS_EN
    ,
    .redirect_count  (redirect_count),
    .squash_count    (squash_count)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // imem environment
  logic [31:0] imq_addr[$];
  int          imq_due[$];
  int          cyc;
  int          lat;
  bit          hold_rsp;

  // reference model
  logic [31:0] m_pc;
  bit          m_boot;
  int          m_inflight;
  int          m_drop;
  logic [31:0] m_fq_pc[$];
  logic [31:0] m_fq_data[$];
  logic [31:0] m_pcq[$];
  int          m_redirects;
  int          m_squash;

  // observation logs
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  logic [31:0] pop_log[$];
  int          pop_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_boot = 1'b1; m_inflight = 0; m_drop = 0;
    m_fq_pc.delete(); m_fq_data.delete(); m_pcq.delete();
    m_redirects = 0; m_squash = 0;
    imq_addr.delete(); imq_due.delete();
    acc_log.delete(); acc_cyc.delete(); pop_log.delete(); pop_cyc.delete();
  endtask

  // Called at a negedge with the test's inputs already set; returns at the next negedge.
  task automatic step();
    bit          rsp;
    bit          exp_rv;
    bit          acc;
    bit          pop;
    logic [31:0] rdata;
    rsp   = !hold_rsp && (imq_addr.size() > 0) && (imq_due[0] <= cyc);
    rdata = rsp ? mem_word(imq_addr[0]) : 32'hDEAD_BEEF;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    exp_rv = !m_boot && !pc_reset_branch && ((m_inflight + m_fq_pc.size()) < 4);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", instr_valid, m_fq_pc.size() > 0);
    if (m_fq_pc.size() > 0) begin
      chk("instr_data", instr_data, m_fq_data[0]);
      chk("instr_pc", instr_pc, m_fq_pc[0]);
    end
`ifdef FETCH_STATS_EN
    chk("redirect_count", redirect_count, m_redirects);
    chk("squash_count", squash_count, m_squash);
`endif
    if (rsp) begin
      void'(imq_addr.pop_front());
      void'(imq_due.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      imq_addr.push_back(imem_req_addr);
      imq_due.push_back(cyc + lat);
      acc_log.push_back(imem_req_addr);
      acc_cyc.push_back(cyc);
    end
    if (instr_valid && instr_ready && !pc_reset_branch) begin
      pop_log.push_back(instr_pc);
      pop_cyc.push_back(cyc);
    end
    acc = exp_rv && imem_req_ready;
    pop = (m_fq_pc.size() > 0) && instr_ready;
    if (pc_reset_branch) begin
      m_redirects++;
      m_squash += m_fq_pc.size() + int'(rsp);
      m_pc = {reset_address[31:2], 2'b00};
      m_fq_pc.delete(); m_fq_data.delete(); m_pcq.delete();
      if (rsp) m_inflight--;
      m_drop = m_inflight;
    end else begin
      if (pop) begin
        void'(m_fq_pc.pop_front());
        void'(m_fq_data.pop_front());
      end
      if (rsp) begin
        m_inflight--;
        if (m_drop > 0) begin
          m_drop--;
          m_squash++;
        end else begin
          m_fq_pc.push_back(m_pcq.pop_front());
          m_fq_data.push_back(rdata);
        end
      end
      if (acc) begin
        m_pcq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
        m_inflight++;
      end
    end
    m_boot = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    pc_reset_branch = 1'b0; reset_address = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    instr_ready = 1'b0; hold_rsp = 1'b0; lat = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic redirect(input logic [31:0] target);
    pc_reset_branch = 1'b1;
    reset_address   = target;
    step();
    pc_reset_branch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int found;
    rst_n = 1'b0;
    cyc = 0;
    idle_inputs();
    model_reset();

    // 1: streaming with 1-cycle imem
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (12) step();
    chk("t1_first_acc_cycle", acc_cyc[0], 1);
    chk("t1_acc0", acc_log[0], 32'h0);
    chk("t1_acc1", acc_log[1], 32'h4);
    chk("t1_acc2", acc_log[2], 32'h8);
    chk("t1_pop0_pc", pop_log[0], 32'h0);
    chk("t1_pop0_cycle", pop_cyc[0], 3);
    chk("t1_pop1_pc", pop_log[1], 32'h4);

    // 2: credit limit with decode stalled and imem holding responses
    do_reset();
    imem_req_ready = 1'b1; hold_rsp = 1'b1;
    repeat (8) step();
    chk("t2_accepts", acc_log.size(), 4);
    chk("t2_last_addr", acc_log[3], 32'hC);
    chk("t2_stalled", imem_req_valid, 0);
    hold_rsp = 1'b0;
    step();
    hold_rsp = 1'b1;
    chk("t2_rsp_no_pop", imem_req_valid, 0);
    instr_ready = 1'b1;
    step();
    chk("t2_after_pop", imem_req_valid, 1);
    hold_rsp = 1'b0; lat = 2;
    repeat (12) step();

    // 3: redirect with 2 outstanding and 1 buffered
    do_reset();
    imem_req_ready = 1'b1; hold_rsp = 1'b1;
    repeat (4) step();
    imem_req_ready = 1'b0; hold_rsp = 1'b0;
    step();
    hold_rsp = 1'b1; imem_req_ready = 1'b1;
    redirect(32'h0000_0100);
    chk("t3_fifo_flushed", instr_valid, 0);
    hold_rsp = 1'b0; instr_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        found = 1;
        break;
      end
      step();
    end
    chk("t3_found_head", found, 1);
    chk("t3_head_pc", instr_pc, 32'h0000_0100);
`ifdef FETCH_STATS_EN
    chk("t3_redirects", redirect_count, 32'd1);
    chk("t3_squashed", squash_count, 32'd3);
`endif
    repeat (6) step();

    // 4: redirect coinciding with a response and a ready imem
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (5) step();
    base  = acc_log.size();
    found = pop_log.size();
    redirect(32'h0000_0200);
    chk("t4_no_accept", acc_log.size(), base);
    chk("t4_next_addr", imem_req_addr, 32'h0000_0200);
    repeat (4) step();
    chk("t4_first_pc", pop_log[found], 32'h0000_0200);

    // 5: target alignment and PC wrap
    redirect(32'h0000_0103);
    chk("t5_aligned", imem_req_addr, 32'h0000_0100);
    repeat (3) step();
    redirect(32'hFFFF_FFFC);
    step();
    chk("t5_wrap_acc", acc_log[acc_log.size() - 1], 32'hFFFF_FFFC);
    chk("t5_wrap_addr", imem_req_addr, 32'h0);
    repeat (6) step();

    // 6: asynchronous reset in the middle of a burst
    do_reset();
    imem_req_ready = 1'b1; lat = 2;
    repeat (6) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_req_addr", imem_req_addr, 32'h0);
    chk("t6_instr_valid", instr_valid, 0);
    chk("t6_instr_data", instr_data, 32'h0);
    chk("t6_instr_pc", instr_pc, 32'h0);
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (8) step();
    chk("t6_restart_pc", pop_log[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
